instr_fetch_unit: RTL and testbench

Instruction fetch front end of the MIPS core: holds the PC, requests instruction words from instruction memory with a variable-latency valid handshake, and presents the fetched word to the controller and datapath. It consumes the controller's `pcsrc` and `jump` decisions to select the next PC, so it drives the other end of the controller interface. It also keeps a retired-instruction counter and a sticky misaligned-target flag.

---
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch front end: PC register, variable-latency imem handshake,
// instruction register, next-PC selection, retire counter and sticky misaligned-branch flag.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] pcbranch,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [31:0] instr_count,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ir_load;
    logic        retire;
    logic [31:0] pc_nxt;
    logic        br_misaligned;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        ir_load     = 1'b0;
        retire      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_load   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Jump outranks branch; a jump never flags the (unused) branch target.
    always_comb begin
        pcplus4       = pc + 32'd4;
        pc_nxt        = pcplus4;
        br_misaligned = 1'b0;
        if (jump) begin
            pc_nxt = {pcplus4[31:28], instr[25:0], 2'b00};
        end else if (pcsrc) begin
            pc_nxt        = {pcbranch[31:2], 2'b00};
            br_misaligned = |pcbranch[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            instr       <= 32'h0000_0000;
            instr_count <= 32'h0000_0000;
            addr_err    <= 1'b0;
        end else begin
            if (ir_load) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc          <= pc_nxt;
                instr_count <= instr_count + 32'd1;
                if (br_misaligned) begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch addresses and retire records are
// queued by the directed stimulus and consumed by independent fetch/retire monitors.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        imem_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] pcbranch = 32'h0;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] instr_count;
    logic        addr_err;

    logic rsp_valid = 1'b0;
    logic pulse_valid = 1'b0;
    assign imem_valid = rsp_valid | pulse_valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] cnt;
    } ret_t;

    logic [31:0] addr_q[$];
    ret_t        ret_q[$];
    ret_t        e;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_cnt = 32'h0;
    int          total = 0;
    int          bad = 0;
    int          mem_wait = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          last_start = -1;
    bit          chk_gap = 1'b0;
    logic        req_prev = 1'b0;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pcsrc(pcsrc), .jump(jump), .pcbranch(pcbranch),
        .pc(pc), .pcplus4(pcplus4), .instr_count(instr_count), .addr_err(addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0020;
            32'h0000_0040: return 32'h0800_0100;
            default:       return {16'h0, a[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: answers after mem_wait request cycles.
    always @(negedge clk) begin
        if (imem_req) begin
            if (wcnt >= mem_wait) begin
                rsp_valid  = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                rsp_valid = 1'b0;
                wcnt++;
            end
        end else begin
            rsp_valid  = 1'b0;
            wcnt       = 0;
            imem_rdata = 32'hDEAD_BEEF;
        end
    end

    // Fetch monitor
    always begin
        @(negedge clk);
        #1;
        if (!reset_n) begin
            req_prev   = 1'b0;
            last_start = -1;
        end else begin
            if (imem_req && !req_prev) begin
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_unexpected: got addr %h expected no request", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, addr_q.pop_front());
                end
                if (chk_gap && last_start >= 0) chk("fetch_gap", 32'(cyc - last_start), 32'd2);
                last_start = cyc;
            end
            req_prev = imem_req;
        end
    end

    // Retire monitor
    always begin
        @(negedge clk);
        #1;
        if (reset_n && instr_valid && instr_ready) begin
            if (ret_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL retire_unexpected: got pc %h expected no retire", pc);
            end else begin
                e = ret_q.pop_front();
                chk("retire_pc", pc, e.pc);
                chk("retire_instr", instr, e.ins);
                chk("retire_count", instr_count, e.cnt);
            end
        end
    end

    task automatic do_reset(input logic pulse, input int wt);
        @(negedge clk);
        reset_n     = 1'b0;
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        jump        = 1'b0;
        pulse_valid = 1'b0;
        #1;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_op", 32'(op), 32'h0);
        chk("rst_funct", 32'(funct), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_count", instr_count, 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        mem_wait = wt;
        exp_pc   = RESET_PC;
        exp_cnt  = 32'h0;
        addr_q.push_back(RESET_PC);
        repeat (2) @(negedge clk);
        reset_n     = 1'b1;
        pulse_valid = pulse;
        @(negedge clk);
        pulse_valid = 1'b0;
    endtask

    task automatic issue(input int hold, input logic ps, input logic jp,
                         input logic [31:0] br, input logic [31:0] nxt);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: instr_valid stayed %b expected 1 at pc %h", instr_valid, exp_pc);
            return;
        end
        ret_q.push_back('{pc: exp_pc, ins: mem_word(exp_pc), cnt: exp_cnt});
        for (int i = 0; i < hold; i++) begin
            pcsrc       = ~pcsrc;
            pcbranch    = 32'h0000_0007;
            pulse_valid = ~pulse_valid;
            @(negedge clk);
            chk("bp_instr", instr, mem_word(exp_pc));
            chk("bp_pc", pc, exp_pc);
            chk("bp_count", instr_count, exp_cnt);
            chk("bp_imem_req", 32'(imem_req), 32'h0);
            chk("bp_instr_valid", 32'(instr_valid), 32'h1);
        end
        pulse_valid = 1'b0;
        instr_ready = 1'b1;
        pcsrc       = ps;
        jump        = jp;
        pcbranch    = br;
        addr_q.push_back(nxt);
        exp_pc  = nxt;
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        jump        = 1'b0;
    endtask

    initial begin
        int n;
        // Sequential fetch, zero-wait memory, ready tied high
        do_reset(1'b0, 0);
        chk("first_req", 32'(imem_req), 32'h1);
        instr_ready = 1'b1;
        chk_gap     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ret_q.push_back('{pc: 32'(4 * i), ins: mem_word(32'(4 * i)), cnt: 32'(i)});
            addr_q.push_back(32'(4 * (i + 1)));
        end
        repeat (8) @(negedge clk);
        chk("seq_count", instr_count, 32'd4);
        instr_ready = 1'b0;
        @(negedge clk);
        chk_gap = 1'b0;

        // Memory wait states: request held 4 cycles at address 0
        do_reset(1'b0, 3);
        chk("wait_req0", 32'(imem_req), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 32'h1);
            chk("wait_addr", imem_addr, 32'h0);
        end
        @(negedge clk);
        chk("wait_req_done", 32'(imem_req), 32'h0);
        chk("wait_instr_valid", 32'(instr_valid), 32'h1);
        chk("wait_op", 32'(op), 32'h0);
        chk("wait_funct", 32'(funct), 32'h20);
        mem_wait = 0;

        // Branch, jump and priority
        issue(0, 1'b0, 1'b0, 32'h0, 32'h4);
        issue(0, 1'b0, 1'b0, 32'h0, 32'h8);
        issue(0, 1'b0, 1'b0, 32'h0, 32'hC);
        issue(0, 1'b0, 1'b0, 32'h0, 32'h10);
        issue(0, 1'b1, 1'b0, 32'h40, 32'h40);
        issue(0, 1'b0, 1'b1, 32'h0, 32'h400);
        issue(0, 1'b1, 1'b1, 32'h103, 32'h1000);
        chk("prio_pc", pc, 32'h1000);
        chk("prio_addr_err", 32'(addr_err), 32'h0);

        // Backpressure, then misaligned branch target
        issue(5, 1'b0, 1'b0, 32'h0, 32'h1004);
        issue(0, 1'b1, 1'b0, 32'h106, 32'h104);
        chk("mis_pc", pc, 32'h104);
        chk("mis_addr_err", 32'(addr_err), 32'h1);
        issue(0, 1'b0, 1'b0, 32'h0, 32'h108);
        issue(0, 1'b0, 1'b0, 32'h0, 32'h10C);
        chk("sticky_addr_err", 32'(addr_err), 32'h1);

        // Reset during a wait state at pc 0x40, stray valid in S_IDLE
        mem_wait = 5;
        issue(0, 1'b1, 1'b0, 32'h40, 32'h40);
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("rw_req", 32'(imem_req), 32'h1);
        chk("rw_pc", pc, 32'h40);
        do_reset(1'b1, 0);
        chk("rw_first_req", 32'(imem_req), 32'h1);
        chk("rw_instr_valid", 32'(instr_valid), 32'h0);
        chk("rw_instr", instr, 32'h0);
        chk("rw_count", instr_count, 32'h0);
        chk("rw_pc0", pc, RESET_PC);
        @(negedge clk);
        chk("rw_ir_loaded", instr, 32'h20);
        repeat (2) @(negedge clk);
        chk("addr_q_empty", 32'(addr_q.size()), 32'h0);
        chk("ret_q_empty", 32'(ret_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
